// File: rtl/rect_pixel_writer.sv
// Clips generator (x, y, colour) tuples to the framebuffer and writes them under fb_ready backpressure.
// Optional counters stat_written/stat_clipped are built when RECT_PIXEL_WRITER_STATS_EN is defined.
module rect_pixel_writer #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                _clock,
    input  logic                _reset_n,
    input  logic                _start,
    input  logic signed [31:0]  _in0,
    input  logic signed [31:0]  _in1,
    input  logic signed [31:0]  _in2,
    input  logic        [31:0]  _in3,
    input  logic                _valid,
    output logic                _ready,
    input  logic                _gen_done,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [DATA_W-1:0]   fb_data,
    input  logic                fb_ready,
`ifdef RECT_PIXEL_WRITER_STATS_EN
    output logic [31:0]         stat_written,
    output logic [31:0]         stat_clipped,
`endif
    output logic                _done,
    output logic                _busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic in_bounds(input logic signed [31:0] x, input logic signed [31:0] y);
        return (x >= 0) && (x < WIDTH) && (y >= 0) && (y < HEIGHT);
    endfunction

    function automatic logic [ADDR_W-1:0] lin_addr(input logic signed [31:0] x, input logic signed [31:0] y);
        logic signed [31:0] lin;
        lin = y * WIDTH + x;
        return lin[ADDR_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic                done_seen_q, done_seen_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]   fb_data_q, fb_data_d;

    logic signed [31:0]  mem_x [DEPTH];
    logic signed [31:0]  mem_y [DEPTH];
    logic [DATA_W-1:0]   mem_c [DEPTH];

    logic                fifo_empty, fifo_full;
    logic                stage_free, push, pop;
    logic signed [31:0]  head_x, head_y;
    logic [DATA_W-1:0]   head_c;
    logic                head_in;
    logic                unused_bits;

    assign unused_bits = ^{_in3, _in2};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // The output register is free when empty or its current write is being taken.
    assign stage_free = !fb_we_q || fb_ready;
    assign push       = _valid && !fifo_full && (state_q == S_RUN);
    assign pop        = !fifo_empty && stage_free;

    assign head_x  = mem_x[rd_ptr_q[AW-1:0]];
    assign head_y  = mem_y[rd_ptr_q[AW-1:0]];
    assign head_c  = mem_c[rd_ptr_q[AW-1:0]];
    assign head_in = in_bounds(head_x, head_y);

    always_comb begin
        state_d     = state_q;
        done_seen_d = done_seen_q;
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        fb_we_d     = fb_we_q;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (_start) begin
                    state_d     = S_RUN;
                    done_seen_d = 1'b0;
                end
            end
            S_RUN: begin
                if (done_seen_q) state_d = S_DRAIN;
                if (_gen_done)   done_seen_d = 1'b1;
            end
            S_DRAIN: begin
                if (fifo_empty && !fb_we_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            fb_we_d = head_in;
            if (head_in) begin
                fb_addr_d = lin_addr(head_x, head_y);
                fb_data_d = head_c;
            end
        end else if (fb_we_q && fb_ready) begin
            fb_we_d = 1'b0;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q     <= S_IDLE;
            done_seen_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
        end
    end

    // Tuple storage carries no reset; occupancy is tracked solely by the pointers.
    always_ff @(posedge _clock) begin
        if (push) begin
            mem_x[wr_ptr_q[AW-1:0]] <= _in0;
            mem_y[wr_ptr_q[AW-1:0]] <= _in1;
            mem_c[wr_ptr_q[AW-1:0]] <= _in2[DATA_W-1:0];
        end
    end

`ifdef RECT_PIXEL_WRITER_STATS_EN
    logic [31:0] written_q, written_d;
    logic [31:0] clipped_q, clipped_d;

    always_comb begin
        written_d = written_q;
        clipped_d = clipped_q;
        if (state_q == S_IDLE && _start) begin
            written_d = '0;
            clipped_d = '0;
        end else begin
            if (fb_we_q && fb_ready) written_d = written_q + 32'd1;
            if (pop && !head_in)     clipped_d = clipped_q + 32'd1;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            written_q <= '0;
            clipped_q <= '0;
        end else begin
            written_q <= written_d;
            clipped_q <= clipped_d;
        end
    end

    assign stat_written = written_q;
    assign stat_clipped = clipped_q;
`endif

    assign _ready  = !fifo_full;
    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign _done   = (state_q == S_DONE);
    assign _busy   = (state_q == S_RUN) || (state_q == S_DRAIN);

endmodule

// File: doc/rect_pixel_writer.md
Name: rect_pixel_writer

Overview:
- Downstream consumer of the rectangle_filled generator. Accepts its signed 32-bit output tuples, buffers them in a small FIFO, and clips each one to the framebuffer bounds.
- In-bounds pixels are written to a single-port framebuffer as address/data strokes, under fb_ready backpressure.
- Signals _done once the generator has finished and every accepted tuple has been retired.

Parameters:
- WIDTH, 64, framebuffer width in pixels (any value ≥1, not necessarily power of two)
- HEIGHT, 48, framebuffer height in pixels
- ADDR_W, 12, framebuffer address width; must satisfy WIDTH*HEIGHT ≤ 2**ADDR_W
- DATA_W, 8, pixel data width
- DEPTH, 4, FIFO depth in tuples (power of two, ≥2)

Ports:
- _clock  input  1  sole clock, rising edge
- _reset_n  input  1  asynchronous active-low reset
- _start  input  1  one-cycle pulse that begins a frame
- _in0  input  32  signed x coordinate (generator _out0)
- _in1  input  32  signed y coordinate (generator _out1)
- _in2  input  32  signed colour; low DATA_W bits used (generator _out2)
- _in3  input  32  ignored (generator _out3)
- _valid  input  1  tuple on _in0.._in3 is valid
- _ready  output  1  block can accept a tuple (= !fifo_full)
- _gen_done  input  1  generator _done; sticky-sampled
- fb_we  output  1  framebuffer write strobe
- fb_addr  output  ADDR_W  write address
- fb_data  output  DATA_W  write data
- fb_ready  input  1  framebuffer accepts the write this cycle
- _done  output  1  one-cycle pulse when the frame is complete
- _busy  output  1  high in RUN or DRAIN

Behaviour:
- Clock and reset: one clock, _clock; reset _reset_n is asynchronous, active-low. Reset drives fb_we=0, fb_addr=0, fb_data=0, _done=0, _busy=0, _ready=1, FIFO empty, state IDLE, done_seen=0.
- State machine:
  - IDLE: on _start go to RUN and clear done_seen.
  - RUN: leave for DRAIN when done_seen=1.
  - DRAIN: when FIFO is empty and no write is pending (fb_we=0), go to DONE.
  - DONE: lasts one cycle with _done=1, then returns to IDLE.
  - _start outside IDLE is ignored.
- Input acceptance:
  - A tuple is pushed on an edge where _valid && _ready && state==RUN.
  - Tuples are dropped in IDLE, DRAIN and DONE; _ready still reflects FIFO space.
  - In RUN, done_seen is set on any edge with _gen_done=1; it stays set until the next _start.
- Full FIFO: _ready=0. No push happens on that edge even if a pop occurs (no bypass); a push is allowed again the following cycle.
- Pop and clip:
  - The head is popped when the output stage is free (fb_we=0, or fb_we && fb_ready) and the FIFO is non-empty.
  - In bounds means 0 ≤ x < WIDTH and 0 ≤ y < HEIGHT, compared as signed 32-bit.
  - In-bounds pixel: on the pop edge, register fb_we=1, fb_addr=y*WIDTH+x (computed at full width, truncated to ADDR_W), fb_data=_in2[DATA_W-1:0].
  - Out-of-bounds pixel: popped and discarded; fb_we is not set by it.
- Latency: a tuple pushed at edge k into an empty FIFO, with fb_ready high, shows fb_we=1 after edge k+1. Sustained throughput is one pixel per cycle.
- Backpressure: while fb_we && !fb_ready, fb_we, fb_addr and fb_data hold stable and nothing is popped.
- _done fires only after the last in-bounds write has been accepted.
- Empty frame: _gen_done arriving with no tuples gives RUN→DRAIN→DONE, with _done two cycles after done_seen is set.
- Asserting _reset_n low mid-frame aborts immediately; no _done is produced.

Optional Feature:
- Macro RECT_PIXEL_WRITER_STATS_EN.
- When defined, add outputs stat_written[31:0] and stat_clipped[31:0].
  - Both clear on _start and on reset.
  - stat_written increments on each accepted write (fb_we && fb_ready).
  - stat_clipped increments on each out-of-bounds pop.
  - Both stay frozen after DONE until the next _start.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single pixel: _start, push (3,2,0x5A) with fb_ready=1, then _gen_done → one write, fb_addr=2*64+3=131, fb_data=0x5A, fb_we high exactly one cycle, then _done pulse.
- Clipping: push (-1,0), (64,0), (0,48), (63,47) → one write at addr 3071; stats build shows written=1, clipped=3.
- Backpressure/full: hold fb_ready=0 and stream 6 tuples → _ready falls after 4 pushes plus 1 in the output stage; fb_addr stays stable. Release fb_ready → all 5 accepted tuples are written in order, with no duplicates or losses.
- Rectangle stream: feed the 5x5 filled rectangle from (0,0), one tuple per cycle, fb_ready=1 → 25 writes at addresses y*64+x in generator order, then _done.
- Reset mid-frame: pull _reset_n low after 3 of 10 writes → fb_we drops asynchronously, no _done. A new _start then behaves like a fresh frame.
- Input gating: pulse _valid in IDLE, and _start while in RUN → no FIFO push, and no state change from the extra _start.
